// File: rtl/asic_host_driver_if.sv
// Host-side bundle between the controller/testbench and the sorting-ASIC driver.
// The slave modport is the driver's view; the master modport is the controller's view.
interface asic_host_driver_if #(
    parameter int DW = 8,
    parameter int CW = 4
);
    logic          Start;
    logic          Load_we;
    logic [CW-1:0] Load_addr;
    logic [DW-1:0] Load_data;
    logic [CW-1:0] Rd_addr;
    logic [DW-1:0] Rd_data;
    logic          Asic_enable;
    logic [DW-1:0] Asic_data_in;
    logic [DW-1:0] Asic_data_out;
    logic          Asic_finish;
    logic          Busy;
    logic          Done;
    logic          Timeout;
    logic [CW:0]   Count;

    modport slave (
        input  Start, Load_we, Load_addr, Load_data, Rd_addr, Asic_data_out, Asic_finish,
        output Rd_data, Asic_enable, Asic_data_in, Busy, Done, Timeout, Count
    );

    modport master (
        output Start, Load_we, Load_addr, Load_data, Rd_addr, Asic_data_out, Asic_finish,
        input  Rd_data, Asic_enable, Asic_data_in, Busy, Done, Timeout, Count
    );
endinterface

// File: rtl/asic_host_driver.sv
// Streams a source buffer into the sorting ASIC, waits for Finish, then
// captures the returned stream into a result buffer readable at any time.
module asic_host_driver #(
    parameter int num_bit_of_data   = 8,
    parameter int num_bit_of_column = 4,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input  logic                 CLK,
    input  logic                 RST,
    asic_host_driver_if.slave    bus
);
    localparam int DW = num_bit_of_data;
    localparam int CW = num_bit_of_column;
    localparam int N  = 2 ** CW;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_RECV, S_DONE, S_TOUT} state_t;

    state_t        r_state;
    logic [DW-1:0] r_src [N];
    logic [DW-1:0] r_res [N];
    logic [CW:0]   r_idx;
    logic [CW:0]   r_cap;
    logic [TW-1:0] r_tmo;
    logic          r_enable;
    logic [DW-1:0] r_din;
    logic          r_busy;
    logic          r_done;
    logic          r_tout;
    logic [CW:0]   r_count;

    logic          w_src_we;
    logic          w_cap_we;
    logic [CW-1:0] w_next_idx;
    logic [CW:0]   w_cap_next;
    logic [DW-1:0] w_first_word;

    assign w_src_we   = bus.Load_we && (r_state == S_IDLE);
    // Data_out is only trusted while Finish is high, so tri-state junk never lands in res.
    assign w_cap_we   = bus.Asic_finish && ((r_state == S_WAIT) || (r_state == S_RECV));
    assign w_next_idx = r_idx[CW-1:0] + CW'(1);
    assign w_cap_next = r_cap + (CW+1)'(1);
    // A word written on the Start cycle must already be what SEND presents first.
    assign w_first_word = (w_src_we && (bus.Load_addr == '0)) ? bus.Load_data : r_src[0];

    always_ff @(posedge CLK) begin
        if (w_src_we)
            r_src[bus.Load_addr] <= bus.Load_data;
        if (w_cap_we && !RST)
            r_res[r_cap[CW-1:0]] <= bus.Asic_data_out;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_cap    <= '0;
            r_tmo    <= '0;
            r_enable <= 1'b0;
            r_din    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_tout   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_done <= 1'b0;
            r_tout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_state  <= S_SEND;
                        r_idx    <= '0;
                        r_cap    <= '0;
                        r_count  <= '0;
                        r_enable <= 1'b1;
                        r_busy   <= 1'b1;
                        r_din    <= w_first_word;
                    end
                end
                S_SEND: begin
                    if (r_idx == (CW+1)'(N-1)) begin
                        r_state <= S_WAIT;
                        r_tmo   <= '0;
                        r_din   <= '0;
                    end else begin
                        r_idx <= r_idx + (CW+1)'(1);
                        r_din <= r_src[w_next_idx];
                    end
                end
                S_WAIT: begin
                    if (bus.Asic_finish) begin
                        r_cap <= (CW+1)'(1);
                        if (N == 1) begin
                            r_state  <= S_DONE;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_count  <= (CW+1)'(1);
                        end else begin
                            r_state <= S_RECV;
                        end
                    end else if (r_tmo == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state  <= S_TOUT;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_tout   <= 1'b1;
                        r_count  <= '0;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_RECV: begin
                    if (bus.Asic_finish) begin
                        r_cap <= w_cap_next;
                        if (w_cap_next == (CW+1)'(N)) begin
                            r_state  <= S_DONE;
                            r_enable <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_count  <= w_cap_next;
                        end
                    end else begin
                        // Finish dropped early: report however many words arrived.
                        r_state  <= S_DONE;
                        r_enable <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_count  <= r_cap;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_TOUT:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.Rd_data      = r_res[bus.Rd_addr];
    assign bus.Asic_enable  = r_enable;
    assign bus.Asic_data_in = r_din;
    assign bus.Busy         = r_busy;
    assign bus.Done         = r_done;
    assign bus.Timeout      = r_tout;
    assign bus.Count        = r_count;
endmodule

// File: tb/tb_asic_host_driver.sv
// Scoreboard bench for asic_host_driver: expected ASIC input words and end-of-transaction
// pulses are queued by the stimulus and popped by a negedge monitor.
module tb_asic_host_driver;
    localparam int DW  = 8;
    localparam int CW  = 4;
    localparam int N   = 16;
    localparam int TMO = 8;

    typedef struct {
        bit is_tout;
        int cnt;
    } evt_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    asic_host_driver_if #(.DW(DW), .CW(CW)) bus ();

    asic_host_driver #(
        .num_bit_of_data  (DW),
        .num_bit_of_column(CW),
        .TIMEOUT_CYCLES   (TMO)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    logic [DW-1:0] exp_din[$];
    evt_t          exp_evt[$];
    int            n_checks = 0;
    int            n_errors = 0;
    int            send_k   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: the first N enabled cycles of each transaction carry source words.
    always @(negedge CLK) begin
        logic [DW-1:0] e;
        evt_t          ev;
        if (bus.Asic_enable) begin
            if (send_k < N) begin
                if (exp_din.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL din_unexpected: got word %0d, expected none", bus.Asic_data_in);
                end else begin
                    e = exp_din.pop_front();
                    chk("asic_data_in", int'(bus.Asic_data_in), int'(e));
                end
                send_k++;
            end
        end else begin
            send_k = 0;
        end
        if (bus.Done || bus.Timeout) begin
            if (exp_evt.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL pulse_unexpected: got Done=%0b Timeout=%0b, expected none", bus.Done, bus.Timeout);
            end else begin
                ev = exp_evt.pop_front();
                chk("pulse_is_timeout", int'(bus.Timeout), int'(ev.is_tout));
                chk("pulse_done", int'(bus.Done), int'(!ev.is_tout));
                chk("count", int'(bus.Count), ev.cnt);
                chk("enable_at_end", int'(bus.Asic_enable), 0);
            end
        end
    end

    task automatic push_src(input int first);
        if (first >= 0) exp_din.push_back(DW'(first));
        else            exp_din.push_back(DW'(15));
        for (int i = 1; i < N; i++) exp_din.push_back(DW'(15 - i));
    endtask

    task automatic push_evt(input bit tout, input int cnt);
        evt_t ev;
        ev.is_tout = tout;
        ev.cnt     = cnt;
        exp_evt.push_back(ev);
    endtask

    task automatic start_tx(input bit ld0, input int v);
        if (ld0) begin
            bus.Load_we   = 1'b1;
            bus.Load_addr = '0;
            bus.Load_data = DW'(v);
        end
        bus.Start = 1'b1;
        tick();
        bus.Start   = 1'b0;
        bus.Load_we = 1'b0;
        repeat (N) tick();
    endtask

    // Plays the ASIC: idle d WAIT cycles, then len words base+k, then waits for Busy to drop.
    task automatic feed(input int d, input int len, input int base, output int t);
        repeat (d) tick();
        for (int k = 0; k < len; k++) begin
            bus.Asic_finish   = 1'b1;
            bus.Asic_data_out = DW'(base + k);
            tick();
        end
        bus.Asic_finish   = 1'b0;
        bus.Asic_data_out = 'z;
        t = 0;
        while (bus.Busy && t < 100) begin
            tick();
            t++;
        end
        if (bus.Busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL busy_timeout: got Busy=1 after %0d cycles, expected 0", t);
        end
        tick();
        tick();
    endtask

    task automatic chk_res(input int i, input int exp);
        bus.Rd_addr = CW'(i);
        #1;
        chk($sformatf("res[%0d]", i), int'(bus.Rd_data), exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t;
        bus.Start = 1'b0; bus.Load_we = 1'b0; bus.Load_addr = '0; bus.Load_data = '0;
        bus.Rd_addr = '0; bus.Asic_finish = 1'b0; bus.Asic_data_out = 'z;

        // Reset held with Start high
        RST = 1'b1;
        bus.Start = 1'b1;
        repeat (2) begin
            tick();
            chk("rst_enable", int'(bus.Asic_enable), 0);
            chk("rst_busy",   int'(bus.Busy), 0);
            chk("rst_done",   int'(bus.Done), 0);
            chk("rst_count",  int'(bus.Count), 0);
            chk("rst_din",    int'(bus.Asic_data_in), 0);
        end
        RST = 1'b0;
        bus.Start = 1'b0;
        tick();
        chk("post_rst_busy", int'(bus.Busy), 0);

        for (int i = 0; i < N; i++) begin
            bus.Load_we = 1'b1; bus.Load_addr = CW'(i); bus.Load_data = DW'(15 - i);
            tick();
        end
        bus.Load_we = 1'b0;

        // Normal flow, ASIC answers after 5 WAIT cycles
        push_src(-1); push_evt(1'b0, 16);
        start_tx(1'b0, 0);
        feed(5, 16, 0, t);
        for (int i = 0; i < N; i++) chk_res(i, i);

        // Timeout: Finish never rises
        push_src(-1); push_evt(1'b1, 0);
        start_tx(1'b0, 0);
        feed(0, 0, 0, t);
        chk("timeout_wait_cycles", t, TMO);
        chk("tout_idle_busy", int'(bus.Busy), 0);

        // Short transfer of 5 words
        push_src(-1); push_evt(1'b0, 5);
        start_tx(1'b0, 0);
        feed(2, 5, 8'hA0, t);
        for (int i = 0; i < 5; i++) chk_res(i, 8'hA0 + i);
        for (int i = 5; i < N; i++) chk_res(i, i);

        // Abort by reset during SEND at idx=7
        for (int i = 0; i < 8; i++) exp_din.push_back(DW'(15 - i));
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        repeat (7) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("abort_enable", int'(bus.Asic_enable), 0);
        chk("abort_busy",   int'(bus.Busy), 0);
        tick();
        chk("abort_no_done", int'(bus.Done), 0);
        push_src(-1); push_evt(1'b0, 16);
        start_tx(1'b0, 0);
        feed(2, 16, 8'h30, t);
        chk_res(0, 8'h30);
        chk_res(15, 8'h3F);

        // Load_we and Start while busy are ignored
        push_src(-1); push_evt(1'b0, 16);
        bus.Start = 1'b1;
        tick();
        bus.Load_we = 1'b1; bus.Load_addr = CW'(3); bus.Load_data = 8'hEE;
        repeat (N) tick();
        bus.Start = 1'b0; bus.Load_we = 1'b0;
        feed(0, 16, 8'h60, t);

        // Start and Load_we together: new word 0 goes out first; word 3 still original
        push_src(8'h55); push_evt(1'b0, 16);
        start_tx(1'b1, 8'h55);
        feed(1, 16, 8'h70, t);
        chk_res(7, 8'h77);

        repeat (3) tick();
        chk("din_queue_drained", exp_din.size(), 0);
        chk("evt_queue_drained", exp_evt.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
